hand_feature_extractor: RTL and testbench
=========================================

// Module: hand_feature_extractor
// PURPOSE
//  Upstream of card_level_detector. Takes one player's 5-card hand serially, one card per handshake.
//  Builds a rank histogram, then scans ranks 14..2 to produce the hand-category flags and ordered
//  tie-break ranks that card_level_detector consumes. One instance per player.
// PARAMETERS
//  RANK_W  4  rank width; legal ranks 2..14 (11=J, 12=Q, 13=K, 14=A)
//  SUIT_W  2  suit width; 4 suits
//  WHEEL_EN  1  1: A-2-3-4-5 counts as a straight with max rank 5
// PORTS
//  clk  in  1  clock
//  rst  in  1  synchronous reset, active-high
//  card_valid  in  1  card present on card_rank/card_suit
//  card_ready  out  1  block can accept a card
//  card_rank  in  RANK_W  card rank
//  card_suit  in  SUIT_W  card suit
//  out_valid  out  1  result fields valid and stable
//  out_ready  in  1  consumer accepts the result
//  out_err  out  1  hand contained an illegal rank (0, 1 or 15)
//  is_four_of_a_kind, is_full_house, is_three_of_a_kind, is_two_pair, is_pair, is_flush, is_straight  out  1 each
//  same_num_max_num_1..4  out  RANK_W each  tie-break ranks, slot 1 most significant
//  flush_max_num  out  RANK_W  highest rank when is_flush=1, else 0
//  straight_max_num  out  RANK_W  top rank of straight (5 for wheel) when is_straight=1, else 0
// BEHAVIOUR
//  - Clock is clk. Reset is synchronous, active-high, on rst.
//  - Reset values: FSM=COLLECT, card count=0, histogram and suit tracking cleared.
//    card_ready=1 while rst is low; all other outputs 0.
//  - FSM:
//    COLLECT: card_ready=1. A card transfers when card_valid&card_ready (one per cycle).
//      Each transfer increments hist[rank], records the suit, and ORs in err if rank is not 2..14.
//      After the 5th transfer -> SCAN.
//    SCAN: 13 cycles, pointer r=14 down to 2. Each cycle:
//      - hist[r]==4 -> quad rank; hist[r]==3 -> trip rank.
//      - hist[r]==2 -> append r to pair list (max 2 entries).
//      - hist[r]==1 -> append r to single list (max 5 entries).
//      - Straight run counter: +1 when hist[r]==1, else reset to 0. A run of 5 sets straight, max=r+4.
//      - WHEEL_EN: at r==2, if run>=4 and hist[14]==1, straight with max=5.
//      Lists fill in descending order. SCAN -> CLASSIFY.
//    CLASSIFY: 1 cycle. Sets flags and slots, then -> DONE.
//      - flush = all 5 suits equal; flush_max = single-list entry 0 (flush implies 5 distinct ranks).
//      - Exactly one same-rank flag is set:
//        quad: flag four, s1=quad, s2=kicker.
//        trip+pair: flag full_house, s1=trip, s2=pair.
//        trip: flag three, s1=trip, s2/s3=kickers high/low.
//        2 pairs: flag two_pair, s1=hi pair, s2=lo pair, s3=kicker.
//        1 pair: flag pair, s1=pair, s2..s4=kickers desc.
//        none: no flag, s1..s4=top 4 singles.
//      - Unused slots=0. Straight-flush asserts both is_flush and is_straight.
//      - err=1: all flags/slots forced 0, out_err=1.
//    DONE: out_valid=1, all result outputs held stable, card_ready=0.
//      On out_valid&out_ready: clear histogram/lists/flags/outputs -> COLLECT.
//      card_ready=1 the following cycle.
//  - Latency: 5th card accepted at cycle N -> out_valid=1 at cycle N+15.
//  - card_valid while card_ready=0 is ignored; no card is lost or double-counted.
//  - Duplicate identical cards are not checked; they are counted as given.
//  - rst in any state, mid-hand or mid-scan, discards everything; the next cycle is COLLECT, count=0.
//  - Outputs are registered. No combinational path from card_* or out_ready to any output.
// TESTING
//  1. K♠K♥K♦K♣3♠ -> four=1, s1=13, s2=3, others 0, out_valid 15 cycles after 5th card.
//  2. 9♥9♠4♦4♣4♥ -> full_house=1, s1=4, s2=9; three/pair/two_pair=0.
//  3. A♦2♣3♥4♠5♦ (WHEEL_EN=1) -> straight=1, straight_max=5, s1..s4=14,5,4,3.
//     Same hand with WHEEL_EN=0 -> straight=0.
//  4. 2♥7♥9♥J♥Q♥ -> flush=1, flush_max=12, no same-rank flag, s1..s4=12,11,9,7.
//  5. 8♣8♦5♠5♥A♣ -> two_pair=1, s1=8, s2=5, s3=14.
//     Hold out_ready=0 10 cycles -> outputs stable, card_ready=0.
//     Drive card_valid=1 during DONE -> ignored.
//  6. Assert rst after 3 cards, then send a full new hand -> result reflects only the new hand.
//     Separately, rank 15 in a hand -> out_err=1, all flags 0.

Source files
------------

// File: rtl/hand_feature_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : hand_feature_extractor
//  Description : Accepts one player's 5-card hand serially (valid/ready), builds
//                a rank histogram, scans ranks 14..2 and emits hand-category
//                flags plus ordered tie-break ranks for card_level_detector.
//  Ports       : clk, rst                - clock, synchronous active-high reset
//                card_valid/card_ready   - card input handshake
//                card_rank/card_suit     - card being offered
//                out_valid/out_ready     - result handshake
//                out_err                 - hand held an illegal rank
//                is_*                    - hand-category flags
//                same_num_max_num_1..4   - tie-break ranks, slot 1 first
//                flush_max_num           - top rank of a flush
//                straight_max_num        - top rank of a straight (5 = wheel)
//  Revision    : 1.0 - initial release
// ============================================================================
module hand_feature_extractor #(
    parameter int RANK_W   = 4,
    parameter int SUIT_W   = 2,
    parameter bit WHEEL_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              card_valid,
    output logic              card_ready,
    input  logic [RANK_W-1:0] card_rank,
    input  logic [SUIT_W-1:0] card_suit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_err,
    output logic              is_four_of_a_kind,
    output logic              is_full_house,
    output logic              is_three_of_a_kind,
    output logic              is_two_pair,
    output logic              is_pair,
    output logic              is_flush,
    output logic              is_straight,
    output logic [RANK_W-1:0] same_num_max_num_1,
    output logic [RANK_W-1:0] same_num_max_num_2,
    output logic [RANK_W-1:0] same_num_max_num_3,
    output logic [RANK_W-1:0] same_num_max_num_4,
    output logic [RANK_W-1:0] flush_max_num,
    output logic [RANK_W-1:0] straight_max_num
);

    localparam int                c_NRANK     = 1 << RANK_W;
    localparam logic [RANK_W-1:0] c_RANK_MIN  = RANK_W'(2);
    localparam logic [RANK_W-1:0] c_RANK_MAX  = RANK_W'(14);
    localparam logic [RANK_W-1:0] c_WHEEL_MAX = RANK_W'(5);
    localparam logic [RANK_W-1:0] c_RUN_SPAN  = RANK_W'(4);

    typedef enum logic [1:0] {
        ST_COLLECT  = 2'd0,
        ST_SCAN     = 2'd1,
        ST_CLASSIFY = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t r_state, w_state_next;

    logic [2:0]        r_hist [c_NRANK];
    logic [2:0]        r_count;
    logic [SUIT_W-1:0] r_suit0;
    logic              r_same_suit;
    logic              r_err;
    logic [RANK_W-1:0] r_ptr;
    // Rank 0 is never a legal rank, so a zero value means "not found".
    logic [RANK_W-1:0] r_quad;
    logic [RANK_W-1:0] r_trip;
    logic [RANK_W-1:0] r_pair [2];
    logic [1:0]        r_npair;
    logic [RANK_W-1:0] r_single [8];
    logic [2:0]        r_nsingle;
    logic [2:0]        r_run;
    logic              r_straight;
    logic [RANK_W-1:0] r_straight_max;

    logic       w_card_fire;
    logic       w_out_fire;
    logic       w_card_bad;
    logic [2:0] w_hcur;
    logic [2:0] w_run_next;

    assign card_ready  = (r_state == ST_COLLECT);
    assign out_valid   = (r_state == ST_DONE);
    assign w_card_fire = card_valid && card_ready;
    assign w_out_fire  = out_valid && out_ready;
    assign w_card_bad  = (card_rank < c_RANK_MIN) || (card_rank > c_RANK_MAX);
    assign w_hcur      = r_hist[r_ptr];
    assign w_run_next  = (w_hcur == 3'd1) ? (r_run + 3'd1) : 3'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_COLLECT:  if (w_card_fire && r_count == 3'd4) w_state_next = ST_SCAN;
            ST_SCAN:     if (r_ptr == c_RANK_MIN) w_state_next = ST_CLASSIFY;
            ST_CLASSIFY: w_state_next = ST_DONE;
            ST_DONE:     if (out_ready) w_state_next = ST_COLLECT;
            default:     w_state_next = ST_COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || w_out_fire) begin
            for (int i = 0; i < c_NRANK; i++) r_hist[i] <= '0;
            for (int i = 0; i < 8; i++) r_single[i] <= '0;
            r_pair[0]          <= '0;
            r_pair[1]          <= '0;
            r_count            <= '0;
            r_suit0            <= '0;
            r_same_suit        <= 1'b1;
            r_err              <= 1'b0;
            r_ptr              <= c_RANK_MAX;
            r_quad             <= '0;
            r_trip             <= '0;
            r_npair            <= '0;
            r_nsingle          <= '0;
            r_run              <= '0;
            r_straight         <= 1'b0;
            r_straight_max     <= '0;
            out_err            <= 1'b0;
            is_four_of_a_kind  <= 1'b0;
            is_full_house      <= 1'b0;
            is_three_of_a_kind <= 1'b0;
            is_two_pair        <= 1'b0;
            is_pair            <= 1'b0;
            is_flush           <= 1'b0;
            is_straight        <= 1'b0;
            same_num_max_num_1 <= '0;
            same_num_max_num_2 <= '0;
            same_num_max_num_3 <= '0;
            same_num_max_num_4 <= '0;
            flush_max_num      <= '0;
            straight_max_num   <= '0;
        end else begin
            case (r_state)
                ST_COLLECT: begin
                    if (w_card_fire) begin
                        r_hist[card_rank] <= r_hist[card_rank] + 3'd1;
                        r_count           <= r_count + 3'd1;
                        if (r_count == 3'd0) r_suit0 <= card_suit;
                        else if (card_suit != r_suit0) r_same_suit <= 1'b0;
                        if (w_card_bad) r_err <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    r_ptr <= r_ptr - RANK_W'(1);
                    r_run <= w_run_next;
                    if (w_hcur == 3'd4) r_quad <= r_ptr;
                    if (w_hcur == 3'd3) r_trip <= r_ptr;
                    if (w_hcur == 3'd2 && r_npair < 2'd2) begin
                        r_pair[r_npair[0]] <= r_ptr;
                        r_npair            <= r_npair + 2'd1;
                    end
                    if (w_hcur == 3'd1 && r_nsingle < 3'd5) begin
                        r_single[r_nsingle] <= r_ptr;
                        r_nsingle           <= r_nsingle + 3'd1;
                    end
                    if (w_run_next == 3'd5) begin
                        r_straight     <= 1'b1;
                        r_straight_max <= r_ptr + c_RUN_SPAN;
                    end else if (WHEEL_EN && r_ptr == c_RANK_MIN && w_run_next == 3'd4
                                 && r_hist[c_RANK_MAX] == 3'd1) begin
                        // 5-4-3-2 run plus a lone ace: the ace plays low.
                        r_straight     <= 1'b1;
                        r_straight_max <= c_WHEEL_MAX;
                    end
                end
                ST_CLASSIFY: begin
                    out_err            <= r_err;
                    is_four_of_a_kind  <= 1'b0;
                    is_full_house      <= 1'b0;
                    is_three_of_a_kind <= 1'b0;
                    is_two_pair        <= 1'b0;
                    is_pair            <= 1'b0;
                    is_flush           <= 1'b0;
                    is_straight        <= 1'b0;
                    same_num_max_num_1 <= '0;
                    same_num_max_num_2 <= '0;
                    same_num_max_num_3 <= '0;
                    same_num_max_num_4 <= '0;
                    flush_max_num      <= '0;
                    straight_max_num   <= '0;
                    if (!r_err) begin
                        is_flush         <= r_same_suit;
                        // A flush has five distinct ranks, so the top single is its max.
                        flush_max_num    <= r_same_suit ? r_single[0] : '0;
                        is_straight      <= r_straight;
                        straight_max_num <= r_straight_max;
                        if (r_quad != '0) begin
                            is_four_of_a_kind  <= 1'b1;
                            same_num_max_num_1 <= r_quad;
                            same_num_max_num_2 <= r_single[0];
                        end else if (r_trip != '0 && r_npair != 2'd0) begin
                            is_full_house      <= 1'b1;
                            same_num_max_num_1 <= r_trip;
                            same_num_max_num_2 <= r_pair[0];
                        end else if (r_trip != '0) begin
                            is_three_of_a_kind <= 1'b1;
                            same_num_max_num_1 <= r_trip;
                            same_num_max_num_2 <= r_single[0];
                            same_num_max_num_3 <= r_single[1];
                        end else if (r_npair == 2'd2) begin
                            is_two_pair        <= 1'b1;
                            same_num_max_num_1 <= r_pair[0];
                            same_num_max_num_2 <= r_pair[1];
                            same_num_max_num_3 <= r_single[0];
                        end else if (r_npair == 2'd1) begin
                            is_pair            <= 1'b1;
                            same_num_max_num_1 <= r_pair[0];
                            same_num_max_num_2 <= r_single[0];
                            same_num_max_num_3 <= r_single[1];
                            same_num_max_num_4 <= r_single[2];
                        end else begin
                            same_num_max_num_1 <= r_single[0];
                            same_num_max_num_2 <= r_single[1];
                            same_num_max_num_3 <= r_single[2];
                            same_num_max_num_4 <= r_single[3];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hand_feature_extractor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hand_feature_extractor
//  Description : Directed self-checking bench for hand_feature_extractor.
//                Suits: 0=spades 1=hearts 2=diamonds 3=clubs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hand_feature_extractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic       out_ready;

    logic       card_ready, out_valid, out_err;
    logic       four, full, three, two, pair, flush, straight;
    logic [3:0] s1, s2, s3, s4, flush_max, straight_max;

    logic       nw_card_ready, nw_out_valid, nw_out_err;
    logic       nw_four, nw_full, nw_three, nw_two, nw_pair, nw_flush, nw_straight;
    logic [3:0] nw_s1, nw_s2, nw_s3, nw_s4, nw_flush_max, nw_straight_max;

    logic [6:0]  flags;
    logic [15:0] slots;
    assign flags = {four, full, three, two, pair, flush, straight};
    assign slots = {s1, s2, s3, s4};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    hand_feature_extractor #(.RANK_W(4), .SUIT_W(2), .WHEEL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .card_valid(card_valid), .card_ready(card_ready),
        .card_rank(card_rank), .card_suit(card_suit), .out_valid(out_valid),
        .out_ready(out_ready), .out_err(out_err),
        .is_four_of_a_kind(four), .is_full_house(full), .is_three_of_a_kind(three),
        .is_two_pair(two), .is_pair(pair), .is_flush(flush), .is_straight(straight),
        .same_num_max_num_1(s1), .same_num_max_num_2(s2),
        .same_num_max_num_3(s3), .same_num_max_num_4(s4),
        .flush_max_num(flush_max), .straight_max_num(straight_max)
    );

    hand_feature_extractor #(.RANK_W(4), .SUIT_W(2), .WHEEL_EN(1'b0)) dut_nowheel (
        .clk(clk), .rst(rst), .card_valid(card_valid), .card_ready(nw_card_ready),
        .card_rank(card_rank), .card_suit(card_suit), .out_valid(nw_out_valid),
        .out_ready(out_ready), .out_err(nw_out_err),
        .is_four_of_a_kind(nw_four), .is_full_house(nw_full), .is_three_of_a_kind(nw_three),
        .is_two_pair(nw_two), .is_pair(nw_pair), .is_flush(nw_flush), .is_straight(nw_straight),
        .same_num_max_num_1(nw_s1), .same_num_max_num_2(nw_s2),
        .same_num_max_num_3(nw_s3), .same_num_max_num_4(nw_s4),
        .flush_max_num(nw_flush_max), .straight_max_num(nw_straight_max)
    );

    task automatic send_card(input logic [3:0] r, input logic [1:0] s);
        @(negedge clk);
        card_valid = 1'b1;
        card_rank  = r;
        card_suit  = s;
        @(posedge clk);
        #1;
        card_valid = 1'b0;
    endtask

    task automatic send_hand(input logic [19:0] rk, input logic [9:0] st);
        for (int i = 0; i < 5; i++) send_card(rk[19-4*i -: 4], st[9-2*i -: 2]);
    endtask

    // Counts clock edges after the 5th card until out_valid; 40 means timeout.
    task automatic wait_result(output int lat);
        lat = 0;
        while (lat < 40 && out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({card_ready, out_valid, out_err} !== 3'b100) begin
            n_errors++;
            $display("FAIL reset_ctrl: got ready/valid/err=%b expected 100", {card_ready, out_valid, out_err});
        end
        n_checks++;
        if ({flags, slots, flush_max, straight_max} !== 31'd0) begin
            n_errors++;
            $display("FAIL reset_data: got flags=%b slots=%h expected all zero", flags, slots);
        end
    endtask

    task automatic test_four;
        int lat;
        send_hand({4'd13, 4'd13, 4'd13, 4'd13, 4'd3}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        wait_result(lat);
        n_checks++;
        if (lat != 14) begin
            n_errors++;
            $display("FAIL four_latency: got %0d edges expected 14", lat);
        end
        n_checks++;
        if (flags !== 7'b1000000 || slots !== 16'hD300) begin
            n_errors++;
            $display("FAIL four_result: got flags=%b slots=%h expected 1000000 D300", flags, slots);
        end
        n_checks++;
        if ({out_err, flush_max, straight_max} !== 9'd0) begin
            n_errors++;
            $display("FAIL four_extra: got err=%b fmax=%0d smax=%0d expected 0", out_err, flush_max, straight_max);
        end
        release_result();
        n_checks++;
        if (out_valid !== 1'b0 || card_ready !== 1'b1 || flags !== 7'd0 || slots !== 16'd0) begin
            n_errors++;
            $display("FAIL four_release: got valid=%b ready=%b flags=%b slots=%h expected 0 1 0 0",
                     out_valid, card_ready, flags, slots);
        end
    endtask

    task automatic test_full_house;
        int lat;
        send_hand({4'd9, 4'd9, 4'd4, 4'd4, 4'd4}, {2'd1, 2'd0, 2'd2, 2'd3, 2'd1});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0100000 || slots !== 16'h4900) begin
            n_errors++;
            $display("FAIL full_house: got lat=%0d flags=%b slots=%h expected 14 0100000 4900", lat, flags, slots);
        end
        release_result();
    endtask

    task automatic test_wheel;
        int lat;
        send_hand({4'd14, 4'd2, 4'd3, 4'd4, 4'd5}, {2'd2, 2'd3, 2'd1, 2'd0, 2'd2});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0000001 || straight_max !== 4'd5 || slots !== 16'hE543) begin
            n_errors++;
            $display("FAIL wheel_en1: got lat=%0d flags=%b smax=%0d slots=%h expected 14 0000001 5 E543",
                     lat, flags, straight_max, slots);
        end
        n_checks++;
        if (nw_out_valid !== 1'b1 || nw_straight !== 1'b0 || nw_straight_max !== 4'd0
            || {nw_s1, nw_s2, nw_s3, nw_s4} !== 16'hE543) begin
            n_errors++;
            $display("FAIL wheel_en0: got valid=%b straight=%b smax=%0d expected 1 0 0",
                     nw_out_valid, nw_straight, nw_straight_max);
        end
        release_result();
    endtask

    task automatic test_flush;
        int lat;
        send_hand({4'd2, 4'd7, 4'd9, 4'd11, 4'd12}, {2'd1, 2'd1, 2'd1, 2'd1, 2'd1});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0000010 || flush_max !== 4'd12 || slots !== 16'hCB97
            || straight_max !== 4'd0) begin
            n_errors++;
            $display("FAIL flush: got lat=%0d flags=%b fmax=%0d slots=%h expected 14 0000010 12 CB97",
                     lat, flags, flush_max, slots);
        end
        release_result();
    endtask

    task automatic test_two_pair_hold;
        int lat;
        int bad;
        send_hand({4'd8, 4'd8, 4'd5, 4'd5, 4'd14}, {2'd3, 2'd2, 2'd0, 2'd1, 2'd3});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0001000 || slots !== 16'h85E0) begin
            n_errors++;
            $display("FAIL two_pair: got lat=%0d flags=%b slots=%h expected 14 0001000 85E0", lat, flags, slots);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            card_valid = 1'b1;
            card_rank  = 4'd2;
            card_suit  = 2'd0;
            @(posedge clk);
            #1;
            if (out_valid !== 1'b1 || card_ready !== 1'b0 || flags !== 7'b0001000 || slots !== 16'h85E0)
                bad++;
        end
        card_valid = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL hold_stable: got %0d unstable cycles expected 0", bad);
        end
        release_result();
    endtask

    task automatic test_three_and_pair;
        int lat;
        send_hand({4'd7, 4'd7, 4'd7, 4'd13, 4'd2}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0010000 || slots !== 16'h7D20) begin
            n_errors++;
            $display("FAIL three: got lat=%0d flags=%b slots=%h expected 14 0010000 7D20", lat, flags, slots);
        end
        release_result();
        send_hand({4'd6, 4'd6, 4'd2, 4'd9, 4'd11}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0000100 || slots !== 16'h6B92) begin
            n_errors++;
            $display("FAIL pair: got lat=%0d flags=%b slots=%h expected 14 0000100 6B92", lat, flags, slots);
        end
        release_result();
    endtask

    task automatic test_back_to_back;
        int lat;
        send_hand({4'd10, 4'd11, 4'd12, 4'd13, 4'd14}, {2'd0, 2'd1, 2'd0, 2'd1, 2'd2});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0000001 || straight_max !== 4'd14 || slots !== 16'hEDCB) begin
            n_errors++;
            $display("FAIL broadway: got lat=%0d flags=%b smax=%0d slots=%h expected 14 0000001 14 EDCB",
                     lat, flags, straight_max, slots);
        end
        release_result();
    endtask

    task automatic test_mid_reset;
        int lat;
        int bad;
        send_card(4'd14, 2'd0);
        send_card(4'd14, 2'd1);
        send_card(4'd14, 2'd2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send_hand({4'd2, 4'd3, 4'd4, 4'd5, 4'd6}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || flags !== 7'b0000001 || straight_max !== 4'd6 || slots !== 16'h6543) begin
            n_errors++;
            $display("FAIL mid_hand_reset: got lat=%0d flags=%b smax=%0d slots=%h expected 14 0000001 6 6543",
                     lat, flags, straight_max, slots);
        end
        release_result();
        send_hand({4'd9, 4'd9, 4'd9, 4'd9, 4'd2}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (out_valid !== 1'b0 || card_ready !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_errors++;
            $display("FAIL mid_scan_reset: got %0d cycles not idle expected 0", bad);
        end
    endtask

    task automatic test_err;
        int lat;
        send_hand({4'd15, 4'd2, 4'd3, 4'd4, 4'd5}, {2'd0, 2'd1, 2'd2, 2'd3, 2'd0});
        wait_result(lat);
        n_checks++;
        if (lat != 14 || out_err !== 1'b1 || flags !== 7'd0 || slots !== 16'd0
            || flush_max !== 4'd0 || straight_max !== 4'd0) begin
            n_errors++;
            $display("FAIL err_rank15: got lat=%0d err=%b flags=%b slots=%h expected 14 1 0 0",
                     lat, out_err, flags, slots);
        end
        release_result();
        n_checks++;
        if (out_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clear: got err=%b expected 0", out_err);
        end
    endtask

    initial begin
        rst        = 1'b0;
        card_valid = 1'b0;
        card_rank  = 4'd0;
        card_suit  = 2'd0;
        out_ready  = 1'b0;
        test_reset();
        test_four();
        test_full_house();
        test_wheel();
        test_flush();
        test_two_pair_hold();
        test_three_and_pair();
        test_back_to_back();
        test_mid_reset();
        test_err();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
